// File: rtl/bsg_mul_iterative_arbiter.sv
// Round-robin front end that shares one iterative multiplier among several requesters.
// It accepts one request at a time, issues it to the multiplier, and holds the tagged product until it is consumed.
module bsg_mul_iterative_arbiter #(
  parameter  int width_p     = 64,
  parameter  int num_req_p   = 4,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p*width_p-1:0]   opA_i,
  input  logic [num_req_p*width_p-1:0]   opB_i,
  input  logic [num_req_p-1:0]           signed_i,
  output logic [num_req_p-1:0]           yumi_o,
  output logic                           v_o,
  output logic [2*width_p-1:0]           result_o,
  output logic [id_width_lp-1:0]         id_o,
  input  logic                           yumi_i,
  output logic                           mul_v_o,
  output logic [width_p-1:0]             mul_opA_o,
  output logic [width_p-1:0]             mul_opB_o,
  output logic                           mul_signed_o,
  input  logic                           mul_ready_i,
  input  logic                           mul_v_i,
  input  logic [2*width_p-1:0]           mul_result_i,
  output logic                           mul_yumi_o
);

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eIssue = 2'd1,
    eWait  = 2'd2,
    eResp  = 2'd3
  } state_e;

  state_e                   state_r;
  logic [id_width_lp-1:0]   rr_ptr_r;
  logic [id_width_lp-1:0]   id_r;
  logic [width_p-1:0]       opa_r;
  logic [width_p-1:0]       opb_r;
  logic                     signed_r;
  logic [2*width_p-1:0]     result_r;
  logic                     v_r;
  logic                     mul_v_r;

  logic                     grant_v_s;
  logic [id_width_lp-1:0]   grant_id_s;
  logic [id_width_lp-1:0]   scan_idx_s;
  logic [width_p-1:0]       grant_opa_s;
  logic [width_p-1:0]       grant_opb_s;
  logic                     grant_signed_s;
  logic [num_req_p-1:0]     yumi_s;
  logic                     mul_yumi_s;

  // Round-robin pick: scan downward so the last hit is the first requester after rr_ptr_r.
  always_comb begin
    grant_v_s  = |v_i;
    grant_id_s = '0;
    scan_idx_s = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      scan_idx_s = id_width_lp'((int'(rr_ptr_r) + k) % num_req_p);
      grant_id_s = v_i[scan_idx_s] ? scan_idx_s : grant_id_s;
    end
  end

  // Winner's operands, selected from the packed request buses.
  always_comb begin
    grant_opa_s    = opA_i[int'(grant_id_s)*width_p +: width_p];
    grant_opb_s    = opB_i[int'(grant_id_s)*width_p +: width_p];
    grant_signed_s = signed_i[grant_id_s];
  end

  // Grant is only visible while idle and out of reset, so nothing is consumed that is not latched.
  always_comb begin
    yumi_s = '0;
    if ((state_r == eIdle) && grant_v_s && !reset_i) begin
      yumi_s[grant_id_s] = 1'b1;
    end else begin
      yumi_s = '0;
    end
  end

  // Result is taken in the same cycle the multiplier presents it.
  always_comb begin
    mul_yumi_s = (state_r == eWait) && mul_v_i && !reset_i;
  end

  // Control FSM with operand, result and handshake registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= eIdle;
      rr_ptr_r <= id_width_lp'(num_req_p - 1);
      id_r     <= '0;
      opa_r    <= '0;
      opb_r    <= '0;
      signed_r <= 1'b0;
      result_r <= '0;
      v_r      <= 1'b0;
      mul_v_r  <= 1'b0;
    end else begin
      case (state_r)
        eIdle: begin
          if (grant_v_s) begin
            opa_r    <= grant_opa_s;
            opb_r    <= grant_opb_s;
            signed_r <= grant_signed_s;
            id_r     <= grant_id_s;
            rr_ptr_r <= grant_id_s;
            mul_v_r  <= 1'b1;
            state_r  <= eIssue;
          end else begin
            state_r  <= eIdle;
          end
        end
        eIssue: begin
          // The multiplier only samples v while ready, so drop v once it has been taken.
          if (mul_ready_i) begin
            mul_v_r <= 1'b0;
            state_r <= eWait;
          end else begin
            state_r <= eIssue;
          end
        end
        eWait: begin
          if (mul_v_i) begin
            result_r <= mul_result_i;
            v_r      <= 1'b1;
            state_r  <= eResp;
          end else begin
            state_r  <= eWait;
          end
        end
        eResp: begin
          if (yumi_i) begin
            v_r     <= 1'b0;
            state_r <= eIdle;
          end else begin
            state_r <= eResp;
          end
        end
        default: begin
          v_r     <= 1'b0;
          mul_v_r <= 1'b0;
          state_r <= eIdle;
        end
      endcase
    end
  end

  assign yumi_o       = yumi_s;
  assign v_o          = v_r;
  assign result_o     = result_r;
  assign id_o         = id_r;
  assign mul_v_o      = mul_v_r;
  assign mul_opA_o    = opa_r;
  assign mul_opB_o    = opb_r;
  assign mul_signed_o = signed_r;
  assign mul_yumi_o   = mul_yumi_s;

endmodule

// File: tb/tb_bsg_mul_iterative_arbiter.sv
// Directed bench for bsg_mul_iterative_arbiter with a simple fixed-latency multiplier model.
module tb_bsg_mul_iterative_arbiter;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [3:0]   v_i;
  logic [255:0] opA_i;
  logic [255:0] opB_i;
  logic [3:0]   signed_i;
  logic [3:0]   yumi_o;
  logic         v_o;
  logic [127:0] result_o;
  logic [1:0]   id_o;
  logic         yumi_i;
  logic         mul_v_o;
  logic [63:0]  mul_opA_o;
  logic [63:0]  mul_opB_o;
  logic         mul_signed_o;
  logic         mul_ready_i;
  logic         mul_v_i;
  logic [127:0] mul_result_i;
  logic         mul_yumi_o;

  int total = 0;
  int bad   = 0;

  // multiplier model state
  logic         ready_en;
  logic         m_busy;
  logic         m_done;
  logic [3:0]   m_cnt;
  logic [127:0] m_res;

  logic [127:0] prod_tbl [4];

  always #5 clk = ~clk;

  bsg_mul_iterative_arbiter #(.width_p(64), .num_req_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .opA_i(opA_i), .opB_i(opB_i),
    .signed_i(signed_i), .yumi_o(yumi_o), .v_o(v_o), .result_o(result_o), .id_o(id_o),
    .yumi_i(yumi_i), .mul_v_o(mul_v_o), .mul_opA_o(mul_opA_o), .mul_opB_o(mul_opB_o),
    .mul_signed_o(mul_signed_o), .mul_ready_i(mul_ready_i), .mul_v_i(mul_v_i),
    .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o)
  );

  function automatic logic [127:0] mul_fn(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    if (s) return sa * sb;
    else   return {64'd0, a} * {64'd0, b};
  endfunction

  assign mul_ready_i  = !m_busy && ready_en;
  assign mul_v_i      = m_done;
  assign mul_result_i = m_res;

  // Multiplier model: accept when ready, produce after a few cycles, hold until yumi.
  always @(posedge clk) begin
    if (reset_i) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 4'd0;
      m_res  <= 128'd0;
    end else if (mul_ready_i && mul_v_o) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'd3;
      m_res  <= mul_fn(mul_opA_o, mul_opB_o, mul_signed_o);
    end else if (m_busy && !m_done) begin
      if (m_cnt == 4'd0) m_done <= 1'b1;
      else               m_cnt  <= m_cnt - 4'd1;
    end else if (m_done && mul_yumi_o) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_req(input int k, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input string tag);
    opA_i[k*64 +: 64] = a;
    opB_i[k*64 +: 64] = b;
    signed_i[k] = s;
    v_i[k] = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (yumi_o != 4'b0000) break;
      step();
    end
    check_val({tag, "_yumi"}, 128'(yumi_o), 128'(4'b0001 << k));
    step();
    v_i[k] = 1'b0;
    #1;
  endtask

  task automatic wait_result(input logic [1:0] exp_id, input logic [127:0] exp_res, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (v_o) break;
      step();
    end
    check_val({tag, "_v"}, 128'(v_o), 128'd1);
    check_val({tag, "_id"}, 128'(id_o), 128'(exp_id));
    check_val({tag, "_res"}, result_o, exp_res);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    #1;
    check_val({tag, "_vdrop"}, 128'(v_o), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i  = 1'b1;
    v_i      = 4'b0000;
    opA_i    = 256'd0;
    opB_i    = 256'd0;
    signed_i = 4'b0000;
    yumi_i   = 1'b0;
    ready_en = 1'b1;
    prod_tbl[0] = 128'd20;
    prod_tbl[1] = 128'd33;
    prod_tbl[2] = 128'd48;
    prod_tbl[3] = 128'd65;
    repeat (3) step();
    reset_i = 1'b0;
    #1;
    check_val("rst_v",      128'(v_o), 128'd0);
    check_val("rst_yumi",   128'(yumi_o), 128'd0);
    check_val("rst_mulv",   128'(mul_v_o), 128'd0);
    check_val("rst_mulyumi",128'(mul_yumi_o), 128'd0);
    check_val("rst_res",    result_o, 128'd0);
    check_val("rst_id",     128'(id_o), 128'd0);
    check_val("rst_opa",    128'(mul_opA_o), 128'd0);

    // unsigned basic
    issue_req(0, 64'd3, 64'd5, 1'b0, "t1");
    wait_result(2'd0, 128'd15, "t1");

    // signed -1 * 7
    issue_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b1, "t2");
    wait_result(2'd1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9, "t2");

    // consumer stall: outputs hold, no new grants while busy
    issue_req(2, 64'd6, 64'd7, 1'b0, "t4");
    opA_i[63:0] = 64'd3;
    opB_i[63:0] = 64'd5;
    signed_i[0] = 1'b0;
    v_i[0] = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (v_o) break;
      step();
    end
    for (int i = 0; i < 10; i++) begin
      check_val("t4_hold_res",  result_o, 128'd42);
      check_val("t4_hold_id",   128'(id_o), 128'd2);
      check_val("t4_hold_yumi", 128'(yumi_o), 128'd0);
      check_val("t4_hold_mulv", 128'(mul_v_o), 128'd0);
      step();
    end
    wait_result(2'd2, 128'd42, "t4");
    issue_req(0, 64'd3, 64'd5, 1'b0, "t4b");
    wait_result(2'd0, 128'd15, "t4b");

    // multiplier not ready: issue holds, other requesters wait
    ready_en = 1'b0;
    issue_req(1, 64'd9, 64'd9, 1'b0, "t6");
    opA_i[3*64 +: 64] = 64'd4;
    opB_i[3*64 +: 64] = 64'd4;
    signed_i[3] = 1'b0;
    v_i[3] = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val("t6_mulv",  128'(mul_v_o), 128'd1);
      check_val("t6_opa",   128'(mul_opA_o), 128'd9);
      check_val("t6_opb",   128'(mul_opB_o), 128'd9);
      check_val("t6_yumi",  128'(yumi_o), 128'd0);
      step();
    end
    ready_en = 1'b1;
    #1;
    wait_result(2'd1, 128'd81, "t6");
    issue_req(3, 64'd4, 64'd4, 1'b0, "t6b");
    wait_result(2'd3, 128'd16, "t6b");

    // reset while waiting on the multiplier drops the operation
    issue_req(2, 64'd1, 64'd1, 1'b0, "t5");
    step();
    check_val("t5_wait_mulv", 128'(mul_v_o), 128'd0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    check_val("t5_rst_v",    128'(v_o), 128'd0);
    check_val("t5_rst_yumi", 128'(yumi_o), 128'd0);
    check_val("t5_rst_mulv", 128'(mul_v_o), 128'd0);
    for (int i = 0; i < 8; i++) begin
      check_val("t5_quiet", 128'({v_o, mul_yumi_o}), 128'd0);
      step();
    end
    issue_req(3, 64'h8000_0000_0000_0000, 64'd2, 1'b0, "t5b");
    wait_result(2'd3, 128'h1_0000_0000_0000_0000, "t5b");

    // all requesting after reset: round-robin 0,1,2,3,0
    reset_i = 1'b1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      opA_i[k*64 +: 64] = 64'(k + 2);
      opB_i[k*64 +: 64] = 64'(k + 10);
    end
    signed_i = 4'b0000;
    v_i = 4'b1111;
    reset_i = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 40; i++) begin
        if (yumi_o != 4'b0000) break;
        step();
      end
      check_val("t3_grant", 128'(yumi_o), 128'(4'b0001 << (g % 4)));
      step();
      wait_result(2'(g % 4), prod_tbl[g % 4], "t3");
    end
    v_i = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
